// File: rtl/cpu_16.sv
// cpu_16: minimal 16-bit multi-cycle Harvard CPU (FETCH -> EXEC -> [MEM]).
// Instruction and data ports use req/rdy handshakes; 16'hFFFF halts the core.

module cpu_16_regs (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  i_ra_sel,
    input  logic [2:0]  i_rb_sel,
    input  logic [2:0]  i_rd_sel,
    output logic [15:0] o_ra,
    output logic [15:0] o_rb,
    output logic [15:0] o_rd,
    input  logic        i_we,
    input  logic [2:0]  i_wa,
    input  logic [15:0] i_wd
);
    logic [15:0] rmem [0:7];

    // NOTE: this storage is a flop array, not a RAM macro, so it can and does take the async reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) rmem[i] <= '0;
        end else if (i_we) begin
            rmem[i_wa] <= i_wd;
        end
    end

    assign o_ra = rmem[i_ra_sel];
    assign o_rb = rmem[i_rb_sel];
    assign o_rd = rmem[i_rd_sel];
endmodule

module cpu_16 #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] ins_rd_addr,
    input  logic [15:0] ins_rd_data,
    output logic        ins_rd_req,
    input  logic        ins_rd_rdy,
    output logic [15:0] dat_rw_addr,
    output logic [15:0] dat_wr_data,
    input  logic [15:0] dat_rd_data,
    output logic        dat_rd_req,
    input  logic        dat_rd_rdy,
    output logic        dat_wr_req,
    input  logic        dat_wr_rdy
);
    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    state_t      r_state, w_next;
    logic        r_run;
    logic [15:0] r_pc;
    logic [15:0] de_ir;
    logic [15:0] r_dat_addr;
    logic [15:0] r_dat_wdata;

    logic [3:0]  w_op;
    logic [2:0]  w_rd, w_ra, w_rb, w_fn;
    logic [15:0] w_s6, w_s9;
    logic [15:0] w_ra_val, w_rb_val, w_rd_val;
    logic [15:0] w_pc_inc, w_pc_next, w_alu, w_exec_wd, w_ea;
    logic        w_halt, w_is_load, w_is_store, w_mem_op, w_exec_we;
    logic        w_fetch_done, w_rf_we;
    logic [15:0] w_rf_wd;

    assign w_op       = de_ir[15:12];
    assign w_rd       = de_ir[11:9];
    assign w_ra       = de_ir[8:6];
    assign w_rb       = de_ir[5:3];
    assign w_fn       = de_ir[2:0];
    assign w_s6       = {{10{de_ir[5]}}, de_ir[5:0]};
    assign w_s9       = {{7{de_ir[8]}}, de_ir[8:0]};
    assign w_halt     = (de_ir == 16'hFFFF);
    assign w_is_load  = (w_op == 4'h2);
    assign w_is_store = (w_op == 4'h3);
    assign w_mem_op   = w_is_load | w_is_store;
    assign w_pc_inc   = r_pc + 16'd1;
    assign w_ea       = w_ra_val + w_s6;

    // r_run holds requests off for the first cycle after reset release, so a stale rdy is ignored
    assign w_fetch_done = (r_state == FETCH) && r_run && ins_rd_rdy;

    assign w_rf_we = ((r_state == EXEC) && w_exec_we) ||
                     ((r_state == MEM) && w_is_load && dat_rd_rdy);
    assign w_rf_wd = (r_state == MEM) ? dat_rd_data : w_exec_wd;

    cpu_16_regs regs (
        .clk      (clk),
        .reset    (reset),
        .i_ra_sel (w_ra),
        .i_rb_sel (w_rb),
        .i_rd_sel (w_rd),
        .o_ra     (w_ra_val),
        .o_rb     (w_rb_val),
        .o_rd     (w_rd_val),
        .i_we     (w_rf_we),
        .i_wa     (w_rd),
        .i_wd     (w_rf_wd)
    );

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_alu = '0;
        case (w_fn)
            3'd0: w_alu = w_ra_val + w_rb_val;
            3'd1: w_alu = w_ra_val - w_rb_val;
            3'd2: w_alu = w_ra_val & w_rb_val;
            3'd3: w_alu = w_ra_val | w_rb_val;
            3'd4: w_alu = w_ra_val ^ w_rb_val;
            3'd5: w_alu = {15'd0, $signed(w_ra_val) < $signed(w_rb_val)};
            3'd6: w_alu = w_ra_val << w_rb_val[3:0];
            3'd7: w_alu = w_ra_val >> w_rb_val[3:0];
            default: w_alu = '0;
        endcase
    end

    // Both links read ra/rd before any write lands, so JALR rd==ra sees the old ra.
    always_comb begin
        w_exec_we = 1'b0;
        w_exec_wd = w_alu;
        w_pc_next = w_pc_inc;
        case (w_op)
            4'h0: w_exec_we = 1'b1;
            4'h1: begin w_exec_we = 1'b1; w_exec_wd = w_ea; end
            4'h4: begin w_exec_we = 1'b1; w_exec_wd = w_s9; end
            4'h5: begin w_exec_we = 1'b1; w_exec_wd = {de_ir[7:0], w_rd_val[7:0]}; end
            4'h6: if (w_rd_val == 16'd0) w_pc_next = w_pc_inc + w_s9;
            4'h7: if (w_rd_val != 16'd0) w_pc_next = w_pc_inc + w_s9;
            4'h8: begin w_exec_we = 1'b1; w_exec_wd = w_pc_inc; w_pc_next = w_pc_inc + w_s9; end
            4'h9: begin w_exec_we = 1'b1; w_exec_wd = w_pc_inc; w_pc_next = w_ra_val; end
            default: ;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH: if (w_fetch_done) w_next = EXEC;
            EXEC: begin
                if (w_halt)        w_next = HALT;
                else if (w_mem_op) w_next = MEM;
                else               w_next = FETCH;
            end
            MEM: if ((w_is_load && dat_rd_rdy) || (w_is_store && dat_wr_rdy)) w_next = FETCH;
            HALT: w_next = HALT;
            default: w_next = FETCH;
        endcase
    end

    always_comb begin
        ins_rd_req = (r_state == FETCH) && r_run;
        dat_rd_req = (r_state == MEM) && w_is_load;
        dat_wr_req = (r_state == MEM) && w_is_store;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run       <= 1'b0;
            r_pc        <= RESET_PC;
            de_ir       <= '0;
            r_dat_addr  <= '0;
            r_dat_wdata <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_fetch_done) de_ir <= ins_rd_data;
            if ((r_state == EXEC) && !w_halt) begin
                r_pc <= w_pc_next;
                if (w_mem_op) begin
                    r_dat_addr  <= w_ea;
                    r_dat_wdata <= w_rd_val;
                end
            end
        end
    end

    assign ins_rd_addr = r_pc;
    assign dat_rw_addr = r_dat_addr;
    assign dat_wr_data = r_dat_wdata;
endmodule

// File: tb/tb_cpu_16.sv
// Self-checking bench for cpu_16: runs small programs against req/rdy slave memories,
// scoreboards expected registers and stores, and checks handshake timing.

module tb_cpu_16;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] ins_rd_addr, ins_rd_data, dat_rw_addr, dat_wr_data, dat_rd_data;
    logic        ins_rd_req, dat_rd_req, dat_wr_req;
    logic        ins_rd_rdy = 1'b0, dat_rd_rdy = 1'b0, dat_wr_rdy = 1'b0;

    cpu_16 #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .ins_rd_addr (ins_rd_addr),
        .ins_rd_data (ins_rd_data),
        .ins_rd_req  (ins_rd_req),
        .ins_rd_rdy  (ins_rd_rdy),
        .dat_rw_addr (dat_rw_addr),
        .dat_wr_data (dat_wr_data),
        .dat_rd_data (dat_rd_data),
        .dat_rd_req  (dat_rd_req),
        .dat_rd_rdy  (dat_rd_rdy),
        .dat_wr_req  (dat_wr_req),
        .dat_wr_rdy  (dat_wr_rdy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [2:0] idx; logic [15:0] val; } rexp_t;
    typedef struct packed { logic [15:0] addr; logic [15:0] data; } sexp_t;

    int          n_total = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          ins_lat = 1;
    int          ins_cnt = 0;
    logic [15:0] imem [0:255];
    logic [15:0] dmem [0:255];
    logic [15:0] prog_q [$];
    rexp_t       reg_q [$];
    sexp_t       st_q [$];
    int          fetch_cnt [0:255];
    int          fetch_cyc [0:255];
    int          wr_len = 0, rd_len = 0;
    logic        snap_v = 1'b0;
    logic [15:0] snap_ir, snap_pc;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Slave memories: data valid only in the rdy cycle, garbage otherwise
    assign ins_rd_data = ins_rd_rdy ? imem[ins_rd_addr[7:0]] : 16'hDEAD;
    assign dat_rd_data = dat_rd_rdy ? dmem[dat_rw_addr[7:0]] : 16'hBEEF;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!ins_rd_req || ins_rd_rdy) begin
            ins_rd_rdy <= 1'b0;
            ins_cnt    <= 0;
        end else if (ins_cnt + 1 >= ins_lat) begin
            ins_rd_rdy <= 1'b1;
        end else begin
            ins_cnt <= ins_cnt + 1;
        end
        dat_rd_rdy <= dat_rd_req && !dat_rd_rdy;
        dat_wr_rdy <= dat_wr_req && !dat_wr_rdy;
        if (!reset) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 16'h0000;
        end else if (dat_wr_req && dat_wr_rdy) begin
            dmem[dat_rw_addr[7:0]] <= dat_wr_data;
        end
    end

    // Monitors sample on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) begin
                fetch_cnt[i] <= 0;
                fetch_cyc[i] <= 0;
            end
            wr_len <= 0;
            rd_len <= 0;
            snap_v <= 1'b0;
        end else begin
            if (ins_rd_req && ins_rd_rdy) begin
                fetch_cnt[ins_rd_addr[7:0]] <= fetch_cnt[ins_rd_addr[7:0]] + 1;
                fetch_cyc[ins_rd_addr[7:0]] <= cyc;
            end
            if (ins_rd_req) begin
                if (snap_v) begin
                    check("stall_ir", dut.de_ir, snap_ir);
                    check("stall_pc", ins_rd_addr, snap_pc);
                end else begin
                    snap_v  <= 1'b1;
                    snap_ir <= dut.de_ir;
                    snap_pc <= ins_rd_addr;
                end
            end else begin
                snap_v <= 1'b0;
            end
            if (dat_wr_req) wr_len <= wr_len + 1;
            else if (wr_len != 0) begin
                check("wr_req_len", 16'(wr_len), 16'd2);
                wr_len <= 0;
            end
            if (dat_rd_req) rd_len <= rd_len + 1;
            else if (rd_len != 0) begin
                check("rd_req_len", 16'(rd_len), 16'd2);
                rd_len <= 0;
            end
            if (dat_wr_req && dat_wr_rdy) begin
                if (st_q.size() == 0) begin
                    check("st_unexpected", 16'(st_q.size()), 16'd1);
                end else begin
                    sexp_t e;
                    e = st_q.pop_front();
                    check("st_addr", dat_rw_addr, e.addr);
                    check("st_data", dat_wr_data, e.data);
                end
            end
        end
    end

    function automatic logic [15:0] enc_alu(input logic [2:0] fn, input logic [2:0] rd,
                                            input logic [2:0] ra, input logic [2:0] rb);
        return {4'h0, rd, ra, rb, fn};
    endfunction
    function automatic logic [15:0] enc_ri(input logic [3:0] op, input logic [2:0] rd,
                                           input logic [2:0] ra, input logic [5:0] s6);
        return {op, rd, ra, s6};
    endfunction
    function automatic logic [15:0] enc_r9(input logic [3:0] op, input logic [2:0] rd,
                                           input logic [8:0] s9);
        return {op, rd, s9};
    endfunction
    function automatic logic [15:0] enc_jalr(input logic [2:0] rd, input logic [2:0] ra);
        return {4'h9, rd, ra, 6'd0};
    endfunction

    task automatic expect_regs(input logic [0:7][15:0] v);
        for (int i = 0; i < 8; i++) reg_q.push_back('{idx: 3'(i), val: v[i]});
    endtask

    task automatic start_prog(input int lat);
        reset   = 1'b0;
        ins_lat = lat;
        for (int i = 0; i < 256; i++) imem[i] = 16'hFFFF;
        for (int i = 0; i < prog_q.size(); i++) imem[i] = prog_q[i];
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_halt(input logic [15:0] halt_pc);
        int    idle = 0;
        int    n = 0;
        rexp_t e;
        while (idle < 10 && n < 3000) begin
            @(negedge clk);
            n++;
            if (ins_rd_req || dat_rd_req || dat_wr_req) idle = 0;
            else idle++;
        end
        check("halt_reached", 16'(idle), 16'd10);
        check("halt_pc", ins_rd_addr, halt_pc);
        while (reg_q.size() != 0) begin
            e = reg_q.pop_front();
            check($sformatf("r%0d", e.idx), dut.regs.rmem[e.idx], e.val);
        end
    endtask

    initial begin
        bit found;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_ins_req", 16'(ins_rd_req), 16'd0);
        check("rst_rd_req", 16'(dat_rd_req), 16'd0);
        check("rst_wr_req", 16'(dat_wr_req), 16'd0);
        check("rst_pc", ins_rd_addr, 16'h0000);
        check("rst_dat_addr", dat_rw_addr, 16'h0000);
        check("rst_wr_data", dat_wr_data, 16'h0000);
        check("rst_de_ir", dut.de_ir, 16'h0000);

        // Basic MOVI / ADD
        prog_q = {enc_r9(4'h4, 3'd1, 9'h005), enc_r9(4'h4, 3'd2, 9'h1FD),
                  enc_alu(3'd0, 3'd3, 3'd1, 3'd2), 16'hFFFF};
        expect_regs({16'h0000, 16'h0005, 16'hFFFD, 16'h0002,
                     16'h0000, 16'h0000, 16'h0000, 16'h0000});
        start_prog(1);
        wait_halt(16'd3);
        check("alu_latency", 16'(fetch_cyc[2] - fetch_cyc[1]), 16'd3);

        // MHI, shifts, SLT, XOR into r0, SW/LW round trip
        prog_q = {enc_r9(4'h4, 3'd1, 9'h034), enc_r9(4'h5, 3'd1, {1'b0, 8'h12}),
                  enc_r9(4'h4, 3'd4, 9'h004), enc_alu(3'd7, 3'd2, 3'd1, 3'd4),
                  enc_ri(4'h3, 3'd1, 3'd0, 6'd2), enc_ri(4'h2, 3'd5, 3'd0, 6'd2),
                  enc_r9(4'h4, 3'd6, 9'h1FF), enc_alu(3'd5, 3'd3, 3'd6, 3'd4),
                  enc_alu(3'd6, 3'd7, 3'd1, 3'd4), enc_alu(3'd4, 3'd0, 3'd1, 3'd2),
                  enc_ri(4'h3, 3'd6, 3'd4, 6'h3F), 16'hFFFF};
        st_q.push_back('{addr: 16'h0002, data: 16'h1234});
        st_q.push_back('{addr: 16'h0003, data: 16'hFFFF});
        expect_regs({16'h1317, 16'h1234, 16'h0123, 16'h0001,
                     16'h0004, 16'h1234, 16'hFFFF, 16'h2340});
        start_prog(1);
        wait_halt(16'd11);
        check("alu_lat2", 16'(fetch_cyc[4] - fetch_cyc[3]), 16'd3);
        check("sw_latency", 16'(fetch_cyc[5] - fetch_cyc[4]), 16'd5);
        check("lw_latency", 16'(fetch_cyc[6] - fetch_cyc[5]), 16'd5);

        // Countdown loop, BZ skip, AND/OR/SUB
        prog_q = {enc_r9(4'h4, 3'd1, 9'h003), enc_ri(4'h1, 3'd1, 3'd1, 6'h3F),
                  enc_r9(4'h7, 3'd1, 9'h1FE), enc_r9(4'h6, 3'd1, 9'h001),
                  enc_r9(4'h4, 3'd2, 9'h007), enc_r9(4'h4, 3'd3, 9'h0F0),
                  enc_r9(4'h4, 3'd4, 9'h03C), enc_alu(3'd2, 3'd5, 3'd3, 3'd4),
                  enc_alu(3'd3, 3'd6, 3'd3, 3'd4), enc_alu(3'd1, 3'd2, 3'd4, 3'd3),
                  16'hFFFF};
        expect_regs({16'h0000, 16'h0000, 16'hFF4C, 16'h00F0,
                     16'h003C, 16'h0030, 16'h00FC, 16'h0000});
        start_prog(1);
        wait_halt(16'd10);
        check("loop_body_x3", 16'(fetch_cnt[1]), 16'd3);
        check("loop_br_x3", 16'(fetch_cnt[2]), 16'd3);
        check("bz_skip", 16'(fetch_cnt[4]), 16'd0);

        // JAL at PC 4, JALR, JALR with rd==ra, no-ops
        prog_q = {enc_r9(4'h4, 3'd1, 9'h008), 16'hA000, 16'hA000, 16'hF000,
                  enc_r9(4'h8, 3'd7, 9'h001), enc_r9(4'h4, 3'd2, 9'h055),
                  enc_jalr(3'd6, 3'd1), enc_r9(4'h4, 3'd3, 9'h001),
                  enc_r9(4'h4, 3'd4, 9'h100), enc_r9(4'h4, 3'd5, 9'h00C),
                  enc_jalr(3'd5, 3'd5), enc_r9(4'h4, 3'd3, 9'h001), 16'hFFFF};
        expect_regs({16'h0000, 16'h0008, 16'h0000, 16'h0000,
                     16'hFF00, 16'h000B, 16'h0007, 16'h0005});
        start_prog(1);
        wait_halt(16'd12);
        check("jal_skip", 16'(fetch_cnt[5]), 16'd0);
        check("jalr_skip", 16'(fetch_cnt[7]), 16'd0);
        check("jalr_same_skip", 16'(fetch_cnt[11]), 16'd0);

        // Stalled instruction slave: same results, longer fetch
        prog_q = {enc_r9(4'h4, 3'd1, 9'h005), enc_r9(4'h4, 3'd2, 9'h1FD),
                  enc_alu(3'd0, 3'd3, 3'd1, 3'd2), 16'hFFFF};
        expect_regs({16'h0000, 16'h0005, 16'hFFFD, 16'h0002,
                     16'h0000, 16'h0000, 16'h0000, 16'h0000});
        start_prog(6);
        wait_halt(16'd3);
        check("stall_latency", 16'(fetch_cyc[2] - fetch_cyc[1]), 16'd8);

        // Reset asserted in the middle of a fetch
        start_prog(4);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (ins_rd_req && ins_rd_addr == 16'd2) found = 1'b1;
        end
        check("midrst_reached", 16'(found), 16'd1);
        reset = 1'b0;
        #1;
        check("midrst_req", 16'(ins_rd_req), 16'd0);
        check("midrst_pc", ins_rd_addr, 16'h0000);
        check("midrst_ir", dut.de_ir, 16'h0000);
        check("midrst_r1", dut.regs.rmem[1], 16'h0000);
        @(negedge clk);
        @(negedge clk);
        ins_lat = 1;
        expect_regs({16'h0000, 16'h0005, 16'hFFFD, 16'h0002,
                     16'h0000, 16'h0000, 16'h0000, 16'h0000});
        reset = 1'b1;
        wait_halt(16'd3);

        check("st_left", 16'(st_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
